// File: rtl/program_loader.sv
// program_loader: streams ASCII program symbols into a 4-bit opcode program memory.
// Optional bracket matching is enabled by defining BRACKET_CHECK_EN.
`default_nettype none

module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_symbol,
    input  logic              i_sym_valid,
    output logic              o_sym_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W:0]   o_length
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] C_CAP            = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_ONE            = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [1:0]      C_ERR_NONE       = 2'b00;
    localparam logic [1:0]      C_ERR_OVERFLOW   = 2'b01;
    localparam logic [1:0]      C_ERR_UNMATCHED  = 2'b10;
    localparam logic [1:0]      C_ERR_UNCLOSED   = 2'b11;
    localparam logic [3:0]      C_OP_OPEN        = 4'd5;
    localparam logic [3:0]      C_OP_CLOSE       = 4'd6;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   r_length;
    logic [1:0]        r_err_code;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_data;

    logic [3:0]        w_opcode;
    logic              w_accept;
    logic              w_restart;
    logic              w_is_term;
    logic              w_is_cmd;
    logic              w_full;
    logic              w_unmatched;
    logic              w_unclosed;

    always_comb begin
        w_opcode = 4'd0;
        case (i_symbol)
            8'h2B:   w_opcode = 4'd1;  // '+'
            8'h2D:   w_opcode = 4'd2;  // '-'
            8'h3E:   w_opcode = 4'd3;  // '>'
            8'h3C:   w_opcode = 4'd4;  // '<'
            8'h5B:   w_opcode = 4'd5;  // '['
            8'h5D:   w_opcode = 4'd6;  // ']'
            8'h2E:   w_opcode = 4'd7;  // '.'
            8'h2C:   w_opcode = 4'd8;  // ','
            default: w_opcode = 4'd0;
        endcase
    end

    // A Start in LOAD takes priority, so the symbol offered alongside it is refused.
    assign o_sym_ready = (r_state == S_LOAD) && !i_start;
    assign w_accept    = i_sym_valid && o_sym_ready;
    assign w_restart   = i_start && (r_state != S_DONE);
    assign w_is_term   = (i_symbol == 8'h00);
    assign w_is_cmd    = (w_opcode != 4'd0);
    assign w_full      = (r_ptr == C_CAP);

`ifdef BRACKET_CHECK_EN
    // Depth can never exceed the pointer, so ADDR_W+1 bits cannot wrap.
    logic [ADDR_W:0] r_depth;
    assign w_unmatched = (w_opcode == C_OP_CLOSE) && (r_depth == '0);
    assign w_unclosed  = (r_depth != '0);
`else
    assign w_unmatched = 1'b0;
    assign w_unclosed  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next_state = S_LOAD;
            S_LOAD: begin
                if (i_start) begin
                    w_next_state = S_LOAD;
                end else if (w_accept) begin
                    if (w_is_term)
                        w_next_state = w_unclosed ? S_ERR : S_DONE;
                    else if (w_is_cmd && (w_full || w_unmatched))
                        w_next_state = S_ERR;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   if (i_start) w_next_state = S_LOAD;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_length   <= '0;
            r_err_code <= C_ERR_NONE;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 4'd0;
`ifdef BRACKET_CHECK_EN
            r_depth    <= '0;
`endif
        end else begin
            r_state  <= w_next_state;
            r_mem_we <= 1'b0;
            if (w_restart) begin
                r_ptr      <= '0;
                r_length   <= '0;
                r_err_code <= C_ERR_NONE;
`ifdef BRACKET_CHECK_EN
                r_depth    <= '0;
`endif
            end else if (w_accept) begin
                if (w_is_term) begin
                    r_length <= r_ptr;
                    if (w_unclosed)
                        r_err_code <= C_ERR_UNCLOSED;
                end else if (w_is_cmd) begin
                    if (w_full) begin
                        r_err_code <= C_ERR_OVERFLOW;
                        r_length   <= C_CAP;
                    end else if (w_unmatched) begin
                        r_err_code <= C_ERR_UNMATCHED;
                    end else begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_ptr[ADDR_W-1:0];
                        r_mem_data <= w_opcode;
                        r_ptr      <= r_ptr + C_ONE;
`ifdef BRACKET_CHECK_EN
                        if (w_opcode == C_OP_OPEN)
                            r_depth <= r_depth + C_ONE;
                        else if (w_opcode == C_OP_CLOSE)
                            r_depth <= r_depth - C_ONE;
`endif
                    end
                end
            end
        end
    end

    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;
    assign o_busy     = (r_state == S_LOAD);
    assign o_done     = (r_state == S_DONE);
    assign o_error    = (r_state == S_ERR);
    assign o_err_code = r_err_code;
    assign o_length   = r_length;

endmodule

`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the program-memory address width; capacity is 2^ADDR_W opcodes.
REQ-002 Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Rst_n  in  1  reset, synchronous and active-low.
REQ-004 Start  in  1  one-cycle request to begin or restart a load.
REQ-005 Symbol  in  8  ASCII program character.
REQ-006 SymValid  in  1  Symbol is valid this cycle.
REQ-007 SymReady  out  1  loader accepts Symbol this cycle; transfer occurs when SymValid and SymReady are both 1.
REQ-008 MemWe  out  1  program-memory write strobe.
REQ-009 MemAddr  out  ADDR_W  write address.
REQ-010 MemData  out  4  opcode written.
REQ-011 Busy  out  1  high in LOAD.
REQ-012 Done  out  1  one-cycle pulse on successful load.
REQ-013 Error  out  1  high while in ERR.
REQ-014 ErrCode  out  2  00 none, 01 overflow, 10 unmatched ']', 11 unclosed '['.
REQ-015 Length  out  ADDR_W+1  opcodes written in the last load.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, DONE and ERR.
REQ-017 IDLE: SymReady=0; Start -> LOAD, clearing the write pointer, bracket depth, Length and ErrCode.
REQ-018 LOAD: SymReady=1; every accepted symbol SHALL be classified by the opcode map: '+'=1, '-'=2, '>'=3, '<'=4, '['=5, ']'=6, '.'=7, ','=8.
REQ-019 Command symbol accepted -> next cycle MemWe=1, MemAddr=pointer, MemData=opcode; pointer increments by 1 (one-cycle registered latency).
REQ-020 Non-command, non-zero symbols SHALL be discarded with no write and no pointer change.
REQ-021 Symbol 8'h00 accepted -> terminator; Length<=pointer; next state DONE, or ERR with code 11 if depth!=0.
REQ-022 DONE lasts exactly one cycle with Done=1, then returns to IDLE; Length holds until the next Start.
REQ-023 Command accepted while pointer==2^ADDR_W (memory full) -> no write; ERR with code 01; Length<=2^ADDR_W.
REQ-024 '[' increments depth; ']' decrements depth; ']' with depth==0 -> no write; ERR with code 10.
REQ-025 Depth counter SHALL be ADDR_W+1 bits and never wrap (bounded by the pointer).
REQ-026 ERR: SymReady=0, Error=1, ErrCode held until Start (-> LOAD, cleared) or reset.
REQ-027 Start in LOAD SHALL abort and restart: the symbol on that cycle is not accepted; pointer, depth and Length are cleared.
REQ-028 MemWe SHALL never be high for more than one cycle per accepted command symbol.

Reset
REQ-029 Rst_n=0 at a clock edge SHALL force IDLE, pointer=0, depth=0, and all outputs to 0, including mid-load; a write already registered is dropped.

Configuration
REQ-030 Macro BRACKET_CHECK_EN defined: depth tracking and codes 10/11 active per REQ-021/REQ-024.
REQ-031 BRACKET_CHECK_EN undefined: no depth logic; '[' and ']' are written like other commands; the terminator always goes to DONE; ErrCode only 00 or 01.

Verification
REQ-032 Start, stream "+[->.<]"+00h -> 7 writes, addr 0..6, data 1,5,2,3,7,4,6; Done pulse; Length=7.
REQ-033 Stream "a +\n-"+00h -> writes only 1 at addr 0 and 2 at addr 1; Length=2; no error.
REQ-034 ADDR_W=2, stream "+++++" -> 4 writes; 5th accepted -> Error=1, ErrCode=01, SymReady=0.
REQ-035 With BRACKET_CHECK_EN: "]"->ErrCode=10, no write; "[+"+00h->ErrCode=11; without it: "[+"+00h -> Done, Length=2.
REQ-036 Rst_n=0 after 3 writes -> next cycle all outputs 0, IDLE; Start then "+"+00h -> write at addr 0, Length=1.
